bridge_deadtime_sequencer: RTL and testbench
============================================

Name: bridge_deadtime_sequencer

Overview:
Sequences H-bridge switch patterns (TOP1-4 / BOT1-4) requested by the command decoder before they reach the gate pins. Every transition into a conducting pattern is preceded by a guaranteed all-off dead interval. Every applied pattern is held for a minimum on-time. Shoot-through patterns are rejected, and a kill input forces all switches off immediately. Sits between the command FSM's requested o_top/o_bot and the O_TOP_x / O_BOT_x outputs.

Parameters:
DEADTIME, 50, all-off cycles required before any non-zero pattern is applied (must be >= 1)
MIN_ON, 500, cycles an applied non-zero pattern is held before a new request is accepted (0 allowed)
CNT_W, 16, width of the dead and on counters (must hold max(DEADTIME, MIN_ON))

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
req_valid  in  1  request strobe
req_top  in  4  requested TOP pattern, bit k-1 = TOPk
req_bot  in  4  requested BOT pattern, bit k-1 = BOTk
req_ready  out  1  request accepted this cycle when req_valid && req_ready
kill  in  1  force all off (error path), level-sensitive
o_top  out  4  registered TOP gate drive
o_bot  out  4  registered BOT gate drive
dead_busy  out  1  high while in S_DEAD
illegal  out  1  one-cycle pulse: accepted request had req_top[k] & req_bot[k] for some k

Behaviour:
- Reset (async, rst=1): o_top=0, o_bot=0, state S_OFF, off_cnt=0, on_cnt=0, pending=0, illegal=0, dead_busy=0. Dead time is enforced after reset.
- off_cnt: cleared to 0 on the edge where outputs go from non-zero to zero. Otherwise it increments on each edge with outputs zero and saturates at DEADTIME-1.
- req_ready = !kill && (state==S_OFF || (state==S_ON && on_cnt==0)). It is 0 in S_DEAD.
- Accepted request, checked in priority order:
  - Illegal pattern: request dropped, illegal=1 next cycle, state and outputs unchanged.
  - Pattern equal to current outputs: no-op.
  - Zero pattern from S_ON: outputs 0 at next edge, state S_OFF, off_cnt=0.
  - Non-zero pattern from S_OFF with off_cnt==DEADTIME-1: outputs take the pattern at next edge (1-cycle latency), state S_ON, on_cnt=MIN_ON.
  - Non-zero pattern otherwise: pending stored, state S_DEAD. From S_ON, outputs go 0 at next edge and off_cnt=0.
- S_DEAD: outputs 0. On the edge after the cycle where off_cnt==DEADTIME-1, outputs take pending, state S_ON, on_cnt=MIN_ON. Outputs are therefore zero for exactly DEADTIME cycles on a direct pattern change.
- S_ON: on_cnt decrements to 0 and holds.
- kill=1 overrides everything, including a simultaneous request (not accepted):
  - Next edge: outputs 0, state S_OFF, pending dropped, on_cnt=0.
  - If outputs were non-zero, off_cnt=0; otherwise off_cnt keeps counting.
  - kill from S_DEAD returns to S_OFF without applying pending.
- Invariant, checked by an assertion: o_top[k] & o_bot[k] is never 1, and any zero-to-non-zero output edge is preceded by >= DEADTIME consecutive zero cycles.
- dead_busy = (state==S_DEAD), registered with state.

Test Plan:
- DEADTIME=8, MIN_ON=4. Reset, then request top=0001 bot=0010 at cycle 0: accepted, o_top/o_bot=0 for 8 cycles, then 0001/0010, req_ready low for 4 cycles after.
- From S_ON 0001/0010 (on_cnt=0), request 0010/0001: outputs 0 at next edge, exactly 8 zero cycles, then 0010/0001, dead_busy high throughout the gap.
- Request top=0001 bot=0001: illegal pulses 1 cycle, outputs and state unchanged, req_ready stays 1.
- Zero request from S_ON, idle 20 cycles, then request 0100/1000: pattern appears at the next edge (no extra dead time).
- kill asserted mid-S_DEAD with a simultaneous req_valid: req_ready=0, outputs stay 0, pending dropped. After kill drops, a new request still waits a full DEADTIME from the last non-zero output.
- rst asserted while in S_ON with a 0100/1000 pattern: outputs 0 immediately (async). After release, the first request waits 8 cycles.

Source files
------------

// File: rtl/bridge_deadtime_sequencer.sv
// H-bridge gate pattern sequencer: inserts an all-off dead interval before every conducting
// pattern, holds patterns for a minimum on-time, rejects shoot-through and honours kill.
module bridge_deadtime_sequencer #(
  parameter int unsigned DEADTIME = 50,
  parameter int unsigned MIN_ON   = 500,
  parameter int unsigned CNT_W    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [3:0] req_top,
  input  logic [3:0] req_bot,
  output logic       req_ready,
  input  logic       kill,
  output logic [3:0] o_top,
  output logic [3:0] o_bot,
  output logic       dead_busy,
  output logic       illegal
);

  localparam logic [CNT_W-1:0] DeadLast = CNT_W'(DEADTIME - 1);
  localparam logic [CNT_W-1:0] MinOn    = CNT_W'(MIN_ON);

  typedef enum logic [1:0] {StOff, StDead, StOn} state_t;

  state_t           state_q, state_d;
  logic [3:0]       top_q, top_d, bot_q, bot_d;
  logic [3:0]       pend_top_q, pend_top_d, pend_bot_q, pend_bot_d;
  logic [CNT_W-1:0] off_cnt_q, off_cnt_d, on_cnt_q, on_cnt_d;
  logic             illegal_q, illegal_d;
  logic             accept, dead_done, cur_zero, next_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StOff;
      top_q      <= '0;
      bot_q      <= '0;
      pend_top_q <= '0;
      pend_bot_q <= '0;
      off_cnt_q  <= '0;
      on_cnt_q   <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      top_q      <= top_d;
      bot_q      <= bot_d;
      pend_top_q <= pend_top_d;
      pend_bot_q <= pend_bot_d;
      off_cnt_q  <= off_cnt_d;
      on_cnt_q   <= on_cnt_d;
      illegal_q  <= illegal_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    top_d      = top_q;
    bot_d      = bot_q;
    pend_top_d = pend_top_q;
    pend_bot_d = pend_bot_q;
    off_cnt_d  = off_cnt_q;
    on_cnt_d   = on_cnt_q;
    illegal_d  = 1'b0;

    req_ready = !kill && (state_q == StOff || (state_q == StOn && on_cnt_q == '0));
    accept    = req_valid && req_ready;
    dead_done = (off_cnt_q == DeadLast);
    cur_zero  = (top_q == 4'd0) && (bot_q == 4'd0);

    if (state_q == StOn && on_cnt_q != '0) on_cnt_d = on_cnt_q - CNT_W'(1);

    if (kill) begin
      top_d      = '0;
      bot_d      = '0;
      state_d    = StOff;
      pend_top_d = '0;
      pend_bot_d = '0;
      on_cnt_d   = '0;
    end else if (state_q == StDead) begin
      if (dead_done) begin
        top_d    = pend_top_q;
        bot_d    = pend_bot_q;
        state_d  = StOn;
        on_cnt_d = MinOn;
      end
    end else if (accept) begin
      if ((req_top & req_bot) != 4'd0) begin
        illegal_d = 1'b1;
      end else if (req_top == top_q && req_bot == bot_q) begin
        state_d = state_q;
      end else if (req_top == 4'd0 && req_bot == 4'd0) begin
        top_d   = '0;
        bot_d   = '0;
        state_d = StOff;
      end else if (state_q == StOff && dead_done) begin
        top_d    = req_top;
        bot_d    = req_bot;
        state_d  = StOn;
        on_cnt_d = MinOn;
      end else begin
        pend_top_d = req_top;
        pend_bot_d = req_bot;
        top_d      = '0;
        bot_d      = '0;
        state_d    = StDead;
      end
    end

    // off_cnt measures the current all-off run; it restarts on the falling edge of conduction.
    next_zero = (top_d == 4'd0) && (bot_d == 4'd0);
    if (!cur_zero && next_zero) begin
      off_cnt_d = '0;
    end else if (cur_zero && !dead_done) begin
      off_cnt_d = off_cnt_q + CNT_W'(1);
    end
  end

  assign o_top     = top_q;
  assign o_bot     = bot_q;
  assign dead_busy = (state_q == StDead);
  assign illegal   = illegal_q;

  a_no_shoot_through: assert property (@(posedge clk) disable iff (rst)
    (top_q & bot_q) == 4'd0);

  a_dead_before_on: assert property (@(posedge clk) disable iff (rst)
    (cur_zero && !next_zero) |-> (off_cnt_q == DeadLast));

endmodule

// File: tb/tb_bridge_deadtime_sequencer.sv
// Bench for bridge_deadtime_sequencer: directed scenarios then random traffic, compared
// every cycle against a run-length based model of the dead-time and on-time rules.
module tb_bridge_deadtime_sequencer;

  localparam int unsigned DT = 8;
  localparam int unsigned MO = 4;
  localparam int MOff  = 0;
  localparam int MDead = 1;
  localparam int MOn   = 2;

  logic       clk = 1'b0;
  logic       rst, req_valid, kill, req_ready, dead_busy, illegal;
  logic [3:0] req_top, req_bot, o_top, o_bot;

  int vectors = 0;
  int miscompares = 0;

  // Model: outputs, mode, pending pattern, length of current all-off run (including the
  // present cycle) and age of the currently applied pattern.
  logic [3:0] m_top, m_bot, p_top, p_bot;
  int         m_mode, zero_run, on_age, obs_zero;
  logic       m_ill;

  bridge_deadtime_sequencer #(.DEADTIME(DT), .MIN_ON(MO), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_top   (req_top),
    .req_bot   (req_bot),
    .req_ready (req_ready),
    .kill      (kill),
    .o_top     (o_top),
    .o_bot     (o_bot),
    .dead_busy (dead_busy),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_top = '0; m_bot = '0; p_top = '0; p_bot = '0;
    m_mode = MOff; zero_run = 1; on_age = 0; obs_zero = 0; m_ill = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; kill = 1'b0; req_valid = 1'b0; req_top = '0; req_bot = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
  endtask

  task automatic step(input logic k, input logic v, input logic [3:0] t, input logic [3:0] b);
    logic       rdy, nill, applied;
    logic [3:0] nt, nb;
    int         nmode;
    @(negedge clk);
    kill = k; req_valid = v; req_top = t; req_bot = b;
    #1;
    rdy = !k && (m_mode == MOff || (m_mode == MOn && on_age >= MO));
    check("req_ready", {3'b0, req_ready}, {3'b0, rdy});
    check("o_top", o_top, m_top);
    check("o_bot", o_bot, m_bot);
    check("dead_busy", {3'b0, dead_busy}, {3'b0, m_mode == MDead});
    check("illegal", {3'b0, illegal}, {3'b0, m_ill});
    check("overlap", o_top & o_bot, 4'd0);
    if ((o_top | o_bot) != 4'd0) begin
      if (obs_zero != 0) check("dead_gap", {3'b0, obs_zero >= DT}, 4'd1);
      obs_zero = 0;
    end else begin
      obs_zero++;
    end

    nt = m_top; nb = m_bot; nmode = m_mode; nill = 1'b0; applied = 1'b0;
    if (k) begin
      nt = '0; nb = '0; nmode = MOff;
    end else if (m_mode == MDead) begin
      if (zero_run >= DT) begin
        nt = p_top; nb = p_bot; nmode = MOn; applied = 1'b1;
      end
    end else if (v && rdy) begin
      if ((t & b) != 4'd0) begin
        nill = 1'b1;
      end else if (t == m_top && b == m_bot) begin
        nmode = m_mode;
      end else if (t == 4'd0 && b == 4'd0) begin
        nt = '0; nb = '0; nmode = MOff;
      end else if (m_mode == MOff && zero_run >= DT) begin
        nt = t; nb = b; nmode = MOn; applied = 1'b1;
      end else begin
        p_top = t; p_bot = b; nt = '0; nb = '0; nmode = MDead;
      end
    end
    if (nt == 4'd0 && nb == 4'd0) zero_run = (m_top == 4'd0 && m_bot == 4'd0) ? zero_run + 1 : 1;
    else zero_run = 0;
    on_age = applied ? 0 : on_age + 1;
    m_top = nt; m_bot = nb; m_mode = nmode; m_ill = nill;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 4'd0);
  endtask

  logic [3:0] pat_top [7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b0101};
  logic [3:0] pat_bot [7] = '{4'b0000, 4'b0010, 4'b0001, 4'b1000, 4'b0100, 4'b1100, 4'b1010};

  initial begin
    do_reset();
    // Request straight out of reset waits the full dead time.
    step(1'b0, 1'b1, 4'b0001, 4'b0010);
    idle(13);
    // Direct pattern change through a dead gap.
    step(1'b0, 1'b1, 4'b0010, 4'b0001);
    idle(13);
    // Shoot-through request is dropped.
    step(1'b0, 1'b1, 4'b0001, 4'b0001);
    idle(2);
    // Zero request, long idle, then immediate apply.
    step(1'b0, 1'b1, 4'b0000, 4'b0000);
    idle(20);
    step(1'b0, 1'b1, 4'b0100, 4'b1000);
    idle(6);
    // Kill mid-dead with a simultaneous request.
    step(1'b0, 1'b1, 4'b0001, 4'b0010);
    idle(3);
    step(1'b1, 1'b1, 4'b0010, 4'b0001);
    step(1'b1, 1'b0, 4'b0000, 4'b0000);
    step(1'b0, 1'b1, 4'b0010, 4'b0001);
    idle(12);
    // Async reset while conducting.
    step(1'b0, 1'b1, 4'b0100, 4'b1000);
    idle(12);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_top", o_top, 4'd0);
    check("async_rst_bot", o_bot, 4'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    kill = 1'b0; req_valid = 1'b0;
    model_reset();
    step(1'b0, 1'b1, 4'b0001, 4'b0010);
    idle(12);

    for (int i = 0; i < 1500; i++) begin
      int r, p;
      logic [3:0] t, b;
      r = $urandom_range(0, 999);
      p = $urandom_range(0, 6);
      t = pat_top[p]; b = pat_bot[p];
      if ($urandom_range(0, 9) == 0) begin
        t = 4'($urandom); b = 4'($urandom);
      end
      if (r < 3) do_reset();
      else step(r < 50, $urandom_range(0, 3) == 0, t, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
